// File: rtl/riscv_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package riscv_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } mem_owner_e;

    localparam int STARVE_CNT_W = 8;

endpackage

// File: rtl/riscv_mem_arb.sv
// Arbitrates one single-port synchronous RAM between instruction fetch (I) and
// data (D). D normally wins; a starvation counter forces an I grant periodically.
module riscv_mem_arb
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  sft_rst,

    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    input  logic                  i_flush,
    output logic                  i_rsp_valid,
    output logic [DATA_WIDTH-1:0] i_rsp_data,

    input  logic                  d_req_valid,
    input  logic                  d_req_we,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_rsp_valid,
    output logic [DATA_WIDTH-1:0] d_rsp_data,

    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
            $error("riscv_mem_arb: STARVE_LIMIT must be within 1..255");
        end
    endgenerate

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    mem_owner_e              rsp_owner_reg;
    mem_owner_e              rsp_owner_next;
    logic [STARVE_CNT_W-1:0] starve_cnt_reg;
    logic [STARVE_CNT_W-1:0] starve_cnt_next;

    logic force_i;
    logic grant_i;
    logic grant_d;
    logic grant_any;

    // Reset gates the grants so nothing reaches the RAM while state is cleared.
    always_comb begin
        force_i   = (starve_cnt_reg == LIMIT);
        grant_i   = !sft_rst && i_req_valid && !i_flush && (!d_req_valid || force_i);
        grant_d   = !sft_rst && d_req_valid && !grant_i;
        grant_any = grant_i || grant_d;
    end

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    always_comb begin
        mem_cs      = grant_any;
        mem_we      = grant_d && d_req_we;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (grant_i) begin
            mem_addr = i_req_addr;
        end else if (grant_d) begin
            mem_addr = d_req_addr;
        end
        if (grant_any) begin
            mem_wr_data = d_req_wdata;
        end
    end

    // Writes never produce a response, so only reads claim ownership.
    always_comb begin
        rsp_owner_next = OWN_NONE;
        if (grant_i) begin
            rsp_owner_next = OWN_I;
        end else if (grant_d && !d_req_we) begin
            rsp_owner_next = OWN_D;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_i || i_flush) begin
            starve_cnt_next = '0;
        end else if (i_req_valid && starve_cnt_reg != LIMIT) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sft_rst) begin
            rsp_owner_reg  <= OWN_NONE;
            starve_cnt_reg <= '0;
        end else begin
            rsp_owner_reg  <= rsp_owner_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // A flush kills a fetch response landing in the same cycle; D is unaffected.
    assign i_rsp_valid = !sft_rst && (rsp_owner_reg == OWN_I) && !i_flush;
    assign d_rsp_valid = !sft_rst && (rsp_owner_reg == OWN_D);
    assign i_rsp_data  = mem_rd_data;
    assign d_rsp_data  = mem_rd_data;

endmodule

// File: tb/tb_riscv_mem_arb.sv
// Directed bench for riscv_mem_arb with a response scoreboard and a RAM model.
module tb_riscv_mem_arb;

    localparam int DW = 64;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          sft_rst;
    logic          i_req_valid;
    logic [AW-1:0] i_req_addr;
    logic          i_req_ready;
    logic          i_flush;
    logic          i_rsp_valid;
    logic [DW-1:0] i_rsp_data;
    logic          d_req_valid;
    logic          d_req_we;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;

    logic          preload;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    riscv_mem_arb #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .sft_rst    (sft_rst),
        .i_req_valid(i_req_valid),
        .i_req_addr (i_req_addr),
        .i_req_ready(i_req_ready),
        .i_flush    (i_flush),
        .i_rsp_valid(i_rsp_valid),
        .i_rsp_data (i_rsp_data),
        .d_req_valid(d_req_valid),
        .d_req_we   (d_req_we),
        .d_req_addr (d_req_addr),
        .d_req_wdata(d_req_wdata),
        .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid),
        .d_rsp_data (d_rsp_data),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: 1-cycle read latency, addresses 0..15 preloaded with 0xA0+addr.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rd_q;
    assign mem_rd_data = rd_q;

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 16; a++) ram[a] <= 64'hA0 + 64'(a);
        end else if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wr_data;
            else        rd_q <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every cycle, the rsp_valid outputs must match the scoreboard head.
    initial begin
        logic ei;
        logic ed;
        forever begin
            @(negedge clk);
            ei = (iq.size() > 0) && (iq[0].cyc == cyc);
            ed = (dq.size() > 0) && (dq[0].cyc == cyc);
            chk("i_rsp_valid", 64'(i_rsp_valid), 64'(ei));
            chk("d_rsp_valid", 64'(d_rsp_valid), 64'(ed));
            if (ei) begin
                if (i_rsp_valid) chk("i_rsp_data", i_rsp_data, iq[0].data);
                void'(iq.pop_front());
            end
            if (ed) begin
                if (d_rsp_valid) chk("d_rsp_data", d_rsp_data, dq[0].data);
                void'(dq.pop_front());
            end
        end
    end

    task automatic step(input logic iv, input logic [AW-1:0] ia, input logic fl,
                        input logic dv, input logic dwe, input logic [AW-1:0] da,
                        input logic [DW-1:0] dwd, input logic rst,
                        input logic exp_ir, input logic exp_dr,
                        input logic push_i, input logic push_d,
                        input logic [DW-1:0] exp_rd, input string tag);
        logic          e_cs;
        logic          e_we;
        logic [AW-1:0] e_addr;
        @(posedge clk);
        #1;
        i_req_valid = iv;  i_req_addr = ia;  i_flush = fl;
        d_req_valid = dv;  d_req_we = dwe;   d_req_addr = da;
        d_req_wdata = dwd; sft_rst = rst;
        e_cs   = exp_ir | exp_dr;
        e_we   = exp_dr & dwe;
        e_addr = exp_ir ? ia : (exp_dr ? da : '0);
        @(negedge clk);
        $display("cyc=%0d %s iv=%0d dv=%0d fl=%0d rst=%0d irdy=%0d drdy=%0d cs=%0d we=%0d addr=%0d",
                 cyc, tag, iv, dv, fl, rst, i_req_ready, d_req_ready, mem_cs, mem_we, mem_addr);
        chk({tag, "_i_ready"}, 64'(i_req_ready), 64'(exp_ir));
        chk({tag, "_d_ready"}, 64'(d_req_ready), 64'(exp_dr));
        chk({tag, "_mem_cs"},  64'(mem_cs),      64'(e_cs));
        chk({tag, "_mem_we"},  64'(mem_we),      64'(e_we));
        chk({tag, "_mem_addr"}, 64'(mem_addr),   64'(e_addr));
        chk({tag, "_mem_wdata"}, mem_wr_data,    e_cs ? dwd : 64'h0);
        if (push_i) iq.push_back('{cyc + 1, exp_rd});
        if (push_d) dq.push_back('{cyc + 1, exp_rd});
    endtask

    initial begin
        logic g;
        preload = 1'b1;
        sft_rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = '0; i_flush = 1'b0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;

        // Reset with requests pending: nothing granted, RAM idle.
        step(1, 14'd1, 0, 1, 0, 14'd2, 64'h0, 1, 0, 0, 0, 0, 64'h0, "rst");
        preload = 1'b0;
        step(1, 14'd1, 0, 1, 1, 14'd2, 64'h55, 1, 0, 0, 0, 0, 64'h0, "rst");
        step(0, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "idle");
        step(0, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "idle");

        // I-only back-to-back fetches.
        step(1, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 1, 0, 1, 0, 64'hA0, "fetch");
        step(1, 14'd1, 0, 0, 0, 14'd0, 64'h0, 0, 1, 0, 1, 0, 64'hA1, "fetch");
        step(1, 14'd2, 0, 0, 0, 14'd0, 64'h0, 0, 1, 0, 1, 0, 64'hA2, "fetch");
        step(0, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "idle");

        // D write then read back; the write yields no response.
        step(0, 14'd0, 0, 1, 1, 14'd5, 64'hDEAD, 0, 0, 1, 0, 0, 64'h0, "dwr");
        step(0, 14'd0, 0, 1, 0, 14'd5, 64'h0, 0, 0, 1, 0, 1, 64'hDEAD, "drd");
        step(0, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "idle");

        // Continuous contention: D,D,D,D,I repeating.
        for (int k = 0; k < 10; k++) begin
            g = (k % 5 == 4);
            step(1, 14'd7, 0, 1, 0, 14'd8, 64'h0, 0, g, !g, g, !g,
                 g ? 64'hA7 : 64'hA8, "arb");
        end
        step(0, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "idle");

        // Fetch of addr 3 flushed in the next cycle: no response, no grant.
        step(1, 14'd3, 0, 0, 0, 14'd0, 64'h0, 0, 1, 0, 0, 0, 64'h0, "fl_issue");
        step(1, 14'd3, 1, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "flush");
        step(1, 14'd3, 0, 0, 0, 14'd0, 64'h0, 0, 1, 0, 1, 0, 64'hA3, "refetch");
        // Build up starvation, flush it away, then the full D,D,D,D,I run must follow.
        step(1, 14'd4, 0, 1, 0, 14'd8, 64'h0, 0, 0, 1, 0, 1, 64'hA8, "starve");
        step(1, 14'd4, 0, 1, 0, 14'd8, 64'h0, 0, 0, 1, 0, 1, 64'hA8, "starve");
        step(1, 14'd4, 1, 1, 0, 14'd9, 64'h0, 0, 0, 1, 0, 1, 64'hA9, "fl_d");
        for (int k = 0; k < 5; k++) begin
            g = (k == 4);
            step(1, 14'd4, 0, 1, 0, 14'd8, 64'h0, 0, g, !g, g, !g,
                 g ? 64'hA4 : 64'hA8, "post_fl");
        end
        step(0, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "idle");

        // D read in flight when reset hits: response dropped, counter cleared.
        step(1, 14'd6, 0, 1, 0, 14'd8, 64'h0, 0, 0, 1, 0, 1, 64'hA8, "pre_rst");
        step(1, 14'd6, 0, 1, 0, 14'd8, 64'h0, 0, 0, 1, 0, 1, 64'hA8, "pre_rst");
        step(0, 14'd0, 0, 1, 0, 14'd9, 64'h0, 0, 0, 1, 0, 0, 64'h0, "rd_drop");
        step(1, 14'd6, 0, 1, 0, 14'd9, 64'h0, 1, 0, 0, 0, 0, 64'h0, "mid_rst");
        step(0, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "idle");
        for (int k = 0; k < 5; k++) begin
            g = (k == 4);
            step(1, 14'd6, 0, 1, 0, 14'd9, 64'h0, 0, g, !g, g, !g,
                 g ? 64'hA6 : 64'hA9, "post_rst");
        end
        step(0, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "idle");
        step(0, 14'd0, 0, 0, 0, 14'd0, 64'h0, 0, 0, 0, 0, 0, 64'h0, "idle");

        chk("i_queue_drained", 64'(iq.size()), 64'h0);
        chk("d_queue_drained", 64'(dq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
